// File: rtl/ber_pkg.sv
// Shared definitions for the 16-QAM PRBS bit-error-rate checker:
// state encoding, default parameters and a 4-bit popcount helper.
package ber_pkg;

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam int DEF_MAX_DELAY   = 31;
    localparam int DEF_TRIAL_LEN   = 64;
    localparam int DEF_LOCK_THRESH = 4;
    localparam int DEF_LOSS_THRESH = 32;
    localparam int DEF_WIN_LOG2    = 22;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/sym_delay_line.sv
// Reference-symbol delay line: shifts one 4-bit symbol per strobe and
// returns the symbol from 'sel' strobes earlier (sel=0 is the live input).
module sym_delay_line
    import ber_pkg::*;
#(
    parameter int MAX_DELAY = DEF_MAX_DELAY,
    parameter int DW        = $clog2(MAX_DELAY + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          sym_ena,
    input  logic [3:0]    din,
    input  logic [DW-1:0] sel,
    output logic [3:0]    dout
);

    localparam int NTAP = 2 ** DW;

    // Tap 0 is the live input; unreachable taps above MAX_DELAY read as 0.
    logic [NTAP-1:0][3:0] w_taps;

    assign w_taps[0] = din;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_DELAY; gi++) begin : g_stage
            logic [3:0] r_stage;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_stage <= 4'b0;
                end else if (clear) begin
                    r_stage <= 4'b0;
                end else if (sym_ena) begin
                    r_stage <= w_taps[gi];
                end
            end

            assign w_taps[gi+1] = r_stage;
        end

        for (gi = MAX_DELAY + 1; gi < NTAP; gi++) begin : g_pad
            assign w_taps[gi] = 4'b0;
        end
    endgenerate

    assign dout = w_taps[sel];

endmodule

// File: rtl/ber_checker.sv
// Receive-side BER checker: searches the channel latency with trial blocks,
// locks onto it, then counts bit/symbol errors over back-to-back windows.
module ber_checker
    import ber_pkg::*;
#(
    parameter  int MAX_DELAY   = DEF_MAX_DELAY,
    parameter  int TRIAL_LEN   = DEF_TRIAL_LEN,
    parameter  int LOCK_THRESH = DEF_LOCK_THRESH,
    parameter  int LOSS_THRESH = DEF_LOSS_THRESH,
    parameter  int WIN_LOG2    = DEF_WIN_LOG2,
    localparam int DW          = $clog2(MAX_DELAY + 1),
    localparam int ERR_W       = WIN_LOG2 + 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sym_ena,
    input  logic               clear,
    input  logic [1:0]         ref_I,
    input  logic [1:0]         ref_Q,
    input  logic [1:0]         rx_I,
    input  logic [1:0]         rx_Q,
    output logic               locked,
    output logic [DW-1:0]      delay,
    output logic [ERR_W-1:0]   ber_bit_errs,
    output logic [WIN_LOG2:0]  ber_sym_errs,
    output logic               ber_valid
);

    localparam int BW = $clog2(TRIAL_LEN + 1);
    localparam int SW = WIN_LOG2 + 1;

    logic [0:0]          r_state;
    logic [DW-1:0]       r_delay;
    logic [BW-1:0]       r_blk_cnt;
    logic [BW-1:0]       r_blk_err;
    logic [WIN_LOG2-1:0] r_win_cnt;
    logic [ERR_W-1:0]    r_win_bit;
    logic [SW-1:0]       r_win_sym;
    logic [ERR_W-1:0]    r_ber_bit;
    logic [SW-1:0]       r_ber_sym;
    logic                r_valid;

    logic [3:0]          w_tap;
    logic [3:0]          w_x;
    logic                w_sym_err;
    logic [2:0]          w_bit_err;
    logic                w_strobe;
    logic                w_is_locked;
    logic                w_blk_last;
    logic [BW-1:0]       w_blk_err_tot;
    logic                w_trial_pass;
    logic                w_blk_lost;
    logic                w_win_last;
    logic [ERR_W-1:0]    w_win_bit_tot;
    logic [SW-1:0]       w_win_sym_tot;
    logic                w_publish;
    logic                w_drop;
    logic [DW-1:0]       w_next_delay;

    sym_delay_line #(
        .MAX_DELAY (MAX_DELAY),
        .DW        (DW)
    ) u_delay_line (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .sym_ena (sym_ena),
        .din     ({ref_I, ref_Q}),
        .sel     (r_delay),
        .dout    (w_tap)
    );

    assign w_x       = {rx_I, rx_Q} ^ w_tap;
    assign w_sym_err = |w_x;
    assign w_bit_err = popcount4(w_x);

    // clear has priority over a coincident strobe
    assign w_strobe    = sym_ena && !clear;
    assign w_is_locked = (r_state == ST_LOCKED);

    assign w_blk_last    = (r_blk_cnt == BW'(TRIAL_LEN - 1));
    assign w_blk_err_tot = r_blk_err + BW'(w_sym_err);
    assign w_trial_pass  = (32'(w_blk_err_tot) < LOCK_THRESH);
    assign w_blk_lost    = (32'(w_blk_err_tot) >= LOSS_THRESH);

    assign w_win_last    = &r_win_cnt;
    assign w_win_bit_tot = r_win_bit + ERR_W'(w_bit_err);
    assign w_win_sym_tot = r_win_sym + SW'(w_sym_err);

    assign w_publish = w_strobe && w_is_locked && w_win_last;
    assign w_drop    = w_strobe && w_is_locked && w_blk_last && w_blk_lost;

    assign w_next_delay = (r_delay == DW'(MAX_DELAY)) ? '0 : r_delay + 1'b1;

    // Search trials and lock-monitor blocks share one block counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blk_cnt <= '0;
            r_blk_err <= '0;
        end else if (clear) begin
            r_blk_cnt <= '0;
            r_blk_err <= '0;
        end else if (sym_ena) begin
            if (w_blk_last) begin
                r_blk_cnt <= '0;
                r_blk_err <= '0;
            end else begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
                r_blk_err <= w_blk_err_tot;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_SEARCH;
            r_delay <= '0;
        end else if (clear) begin
            r_state <= ST_SEARCH;
            r_delay <= '0;
        end else if (sym_ena && w_blk_last) begin
            if (!w_is_locked) begin
                if (w_trial_pass) begin
                    r_state <= ST_LOCKED;
                end else begin
                    r_delay <= w_next_delay;
                end
            end else if (w_blk_lost) begin
                // delay is kept so the last good alignment is retried first
                r_state <= ST_SEARCH;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_cnt <= '0;
            r_win_bit <= '0;
            r_win_sym <= '0;
        end else if (clear || w_publish || w_drop) begin
            r_win_cnt <= '0;
            r_win_bit <= '0;
            r_win_sym <= '0;
        end else if (w_strobe && w_is_locked) begin
            r_win_cnt <= r_win_cnt + 1'b1;
            r_win_bit <= w_win_bit_tot;
            r_win_sym <= w_win_sym_tot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ber_bit <= '0;
            r_ber_sym <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_publish;
            if (w_publish) begin
                r_ber_bit <= w_win_bit_tot;
                r_ber_sym <= w_win_sym_tot;
            end
        end
    end

    assign locked       = w_is_locked;
    assign delay        = r_delay;
    assign ber_bit_errs = r_ber_bit;
    assign ber_sym_errs = r_ber_sym;
    assign ber_valid    = r_valid;

endmodule

// File: doc/ber_checker.md
# ber_checker

Receive-side bit-error-rate checker for the 16-QAM PRBS test link. It consumes the slicer's decided I/Q symbols and the reference I/Q symbols from the transmit PRBS generator. It searches for the channel latency with a programmable symbol delay line and locks onto it. Once locked, it counts symbol and bit errors over fixed measurement windows and publishes each window's totals.

## Interface
- MAX_DELAY, 31: largest searchable channel latency, in symbols; DW = clog2(MAX_DELAY+1)
- TRIAL_LEN, 64: symbols per search trial and per lock-monitor block
- LOCK_THRESH, 4: a trial locks if its symbol errors are < LOCK_THRESH
- LOSS_THRESH, 32: a lock-monitor block drops lock if its symbol errors are >= LOSS_THRESH
- WIN_LOG2, 22: measurement window = 2^WIN_LOG2 symbols; ERR_W = WIN_LOG2+3 (localparam)

- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- sym_ena  in  1  symbol strobe; one-cycle pulse; ref and rx inputs are valid when it is high
- clear  in  1  synchronous restart of acquisition
- ref_I, ref_Q  in  2 each  transmitted reference symbol
- rx_I, rx_Q  in  2 each  received (sliced) symbol
- locked  out  1  alignment found
- delay  out  DW  current or locked delay, in symbols
- ber_bit_errs  out  ERR_W  bit errors in the last completed window
- ber_sym_errs  out  WIN_LOG2+1  symbol errors in the last completed window
- ber_valid  out  1  one-cycle pulse when new totals are loaded

## Operation
- Delay line:
  - On each sym_ena, {ref_I,ref_Q} shifts into a (MAX_DELAY+1)-deep 4-bit line. Reset contents are 0.
  - tap(d) is the reference from d strobes earlier. tap(0) is the current input.
- Compare: x = {rx_I,rx_Q} XOR tap(delay).
  - symbol error = (x != 0).
  - bit errors = popcount(x), range 0..4.
- States: SEARCH, LOCKED. Reset and clear state = SEARCH.
- SEARCH:
  - Each strobe increments trial_cnt and adds the symbol error to trial_err.
  - On the TRIAL_LEN-th strobe, if trial_err < LOCK_THRESH: go to LOCKED, keep delay.
  - Otherwise: delay = (delay==MAX_DELAY) ? 0 : delay+1.
  - trial counters clear in both cases.
- LOCKED:
  - Each strobe increments win_cnt and accumulates win_bit and win_sym.
  - In parallel, TRIAL_LEN-symbol monitor blocks count symbol errors.
  - A block with >= LOSS_THRESH errors returns the block to SEARCH. delay is unchanged, so the same delay is retried first. Window counters clear and no ber_valid is issued.
  - On the 2^WIN_LOG2-th strobe of a window, the totals including that strobe load into ber_bit_errs/ber_sym_errs and ber_valid pulses. Window counters restart at 0, so windows run back-to-back.
- Simultaneous events:
  - Window completion and loss of lock on the same strobe: the window still publishes, then the block goes to SEARCH.
  - clear beats sym_ena: the state becomes SEARCH with delay=0, all counters and the delay line cleared, and locked=0. ber_bit_errs/ber_sym_errs are retained and there is no ber_valid.
- Widths are sized so counters never overflow (max bit errors = 2^(WIN_LOG2+2)). No saturation logic.

## Timing
- Reset values: locked=0, delay=0, ber_bit_errs=0, ber_sym_errs=0, ber_valid=0, state=SEARCH.
- All outputs are registered.
- locked, delay and ber_* update on the clk edge that samples the deciding strobe, i.e. they are visible the cycle after sym_ena.
- The first counted window symbol is the strobe after the lock decision.
- ber_valid is high for exactly one clk cycle and never on consecutive cycles.
- Worst-case acquisition = (MAX_DELAY+1)·TRIAL_LEN strobes.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous). Any partial window is discarded.

## Structure
- Package ber_pkg holds:
  - the state encoding (SEARCH, LOCKED);
  - a 4-bit popcount function;
  - default parameter constants.
- Sub-module sym_delay_line(clk, reset, clear, sym_ena, din[3:0], sel[DW-1:0], dout[3:0]) implements the delay line and tap mux.
- The FSM, counters and result registers live in ber_checker.

## Test plan
Use WIN_LOG2=8, TRIAL_LEN=64 and defaults otherwise. The PRBS feeds ref, and rx = ref delayed by N strobes.
- N=7, no errors -> delays 0..6 fail. locked rises after strobe 512 with delay=7. ber_valid every 256 strobes with ber_bit_errs=0, ber_sym_errs=0.
- Locked at N=7; flip rx_I[0] every 16th symbol -> each window reports ber_bit_errs=16, ber_sym_errs=16.
- Locked; invert all 4 rx bits on one symbol in a window -> ber_bit_errs=4, ber_sym_errs=1.
- Locked at 7; N changes to 9 -> locked drops within 64 strobes. Retry at 7 fails, 8 fails, 9 locks; delay=9.
- Assert reset mid-LOCKED -> locked, delay, ber_* go to 0 in the same cycle. The first ber_valid after release comes only after a fresh lock plus 256 strobes.
- clear coincident with the 256th window strobe -> no ber_valid; state SEARCH, delay=0, ber_* keep their previous values.
